fetch_unit: RTL and testbench

Instruction-fetch stage of the nRISC core, directly upstream of the control unit. Holds the PC, fetches 8-bit instructions from instruction memory over a req/ack handshake, and presents `opCode`/`funct` to the control unit. Waits one cycle for the control unit's registered outputs, then uses `PcWrite`/`Jump`/`Bnez` to compute the next PC or enter halt.

---
 rtl/fetch_unit_if.sv | 24 ++
 rtl/fetch_unit.sv | 126 ++++++++++++
 tb/tb_fetch_unit.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/ack bus between the fetch unit (master) and the
// instruction memory (slave).
interface fetch_unit_if #(
  parameter int PC_WIDTH = 8
);
  logic                imem_req;
  logic [PC_WIDTH-1:0] imem_addr;
  logic                imem_ack;
  logic [7:0]          imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// nRISC instruction-fetch stage: PC, IR and the IDLE/FETCH/DECODE/UPDATE/HALT sequencer.
// Optional fetch watchdog enabled by defining FETCH_TIMEOUT_EN.
module fetch_unit #(
  parameter int                  PC_WIDTH       = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC       = '0,
  parameter int                  TIMEOUT_CYCLES = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                PcWrite,
  input  logic                Jump,
  input  logic                Bnez,
  input  logic                bnez_cond,
  input  logic [PC_WIDTH-1:0] jr_target,
  fetch_unit_if.master        imem,
  output logic [PC_WIDTH-1:0] pc,
  output logic [2:0]          opCode,
  output logic                funct,
  output logic                instr_valid,
  output logic                halted,
  output logic                fetch_fault
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_UPDATE = 3'd3;
  localparam logic [2:0] ST_HALT   = 3'd4;

  logic [2:0]          state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [7:0]          ir_q, ir_d;
  logic                timeout_hit;

  // Branch offset is the 5-bit signed field ir[4:0]; wraps modulo 2^PC_WIDTH.
  function automatic logic [PC_WIDTH-1:0] branch_target(input logic [PC_WIDTH-1:0] base,
                                                         input logic [4:0]          off);
    logic signed [PC_WIDTH-1:0] off_sx;
    off_sx = PC_WIDTH'($signed(off));
    return base + off_sx;
  endfunction

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      ST_IDLE:   state_d = ST_FETCH;
      ST_FETCH: begin
        if (imem.imem_ack) begin
          ir_d    = imem.imem_rdata;
          state_d = ST_DECODE;
        end else if (timeout_hit) begin
          state_d = ST_HALT;
        end
      end
      ST_DECODE: state_d = ST_UPDATE;
      ST_UPDATE: begin
        if (!PcWrite) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_FETCH;
          if (Jump)                  pc_d = jr_target;
          else if (Bnez && bnez_cond) pc_d = branch_target(pc_q, ir_q[4:0]);
          else                       pc_d = pc_q + PC_WIDTH'(1);
        end
      end
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;

  // The last unacknowledged FETCH cycle before the limit triggers the fault.
  assign timeout_hit = (state_q == ST_FETCH) && !imem.imem_ack &&
                       (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d   = '0;
    fault_d = fault_q | timeout_hit;
    if ((state_q == ST_FETCH) && !imem.imem_ack && !timeout_hit)
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  assign fetch_fault = fault_q;
`else
  assign timeout_hit = 1'b0;
  assign fetch_fault = 1'b0;
`endif

  assign imem.imem_req  = (state_q == ST_FETCH);
  assign imem.imem_addr = pc_q;
  assign pc             = pc_q;
  assign opCode         = ir_q[7:5];
  assign funct          = ir_q[0];
  assign instr_valid    = (state_q == ST_DECODE) || (state_q == ST_UPDATE);
  assign halted         = (state_q == ST_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed + randomized bench for fetch_unit; expected PCs come from a
// per-instruction arithmetic model of the next-PC rules.
module tb_fetch_unit;
  localparam int PW = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          PcWrite = 1'b0, Jump = 1'b0, Bnez = 1'b0, bnez_cond = 1'b0;
  logic [PW-1:0] jr_target = '0;
  logic [PW-1:0] pc;
  logic [2:0]    opCode;
  logic          funct, instr_valid, halted, fetch_fault;

  int checks = 0;
  int errors = 0;
  int exp_pc = 0;

  fetch_unit_if #(.PC_WIDTH(PW)) imem_bus();

  fetch_unit #(.PC_WIDTH(PW), .RESET_PC(8'h00), .TIMEOUT_CYCLES(16)) dut (
    .clock(clock), .reset(reset),
    .PcWrite(PcWrite), .Jump(Jump), .Bnez(Bnez), .bnez_cond(bnez_cond),
    .jr_target(jr_target), .imem(imem_bus),
    .pc(pc), .opCode(opCode), .funct(funct),
    .instr_valid(instr_valid), .halted(halted), .fetch_fault(fetch_fault)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Ends at the negedge of the first FETCH cycle after reset release.
  task automatic do_reset();
    reset = 1'b1;
    imem_bus.imem_ack = 1'b0;
    imem_bus.imem_rdata = '0;
    {PcWrite, Jump, Bnez, bnez_cond} = '0;
    repeat (2) @(negedge clock);
    check("rst_pc", pc, 8'h00);
    check("rst_opcode", opCode, 0);
    check("rst_funct", funct, 0);
    check("rst_req", imem_bus.imem_req, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_halted", halted, 0);
    check("rst_fault", fetch_fault, 0);
    reset = 1'b0;
    exp_pc = 0;
    #1 check("idle_req", imem_bus.imem_req, 0);
    @(negedge clock);
    check("first_fetch_req", imem_bus.imem_req, 1);
  endtask

  // Starts at a FETCH negedge; returns at the following FETCH (or HALT) negedge.
  task automatic run_instr(input int dly, input logic [7:0] instr,
                           input logic pw, input logic j, input logic b, input logic c,
                           input logic [7:0] jr);
    int off;
    for (int i = 0; i < dly; i++) begin
      check("req_wait", imem_bus.imem_req, 1);
      check("addr_wait", imem_bus.imem_addr, exp_pc);
      imem_bus.imem_ack = 1'b0;
      imem_bus.imem_rdata = 8'($urandom);
      @(negedge clock);
    end
    check("req_fetch", imem_bus.imem_req, 1);
    check("addr_fetch", imem_bus.imem_addr, exp_pc);
    check("valid_fetch", instr_valid, 0);
    imem_bus.imem_ack = 1'b1;
    imem_bus.imem_rdata = instr;
    @(negedge clock);
    // DECODE: stray acks must not touch ir
    imem_bus.imem_ack = 1'($urandom_range(0, 1));
    imem_bus.imem_rdata = 8'($urandom);
    check("req_decode", imem_bus.imem_req, 0);
    check("valid_decode", instr_valid, 1);
    check("opcode_decode", opCode, instr[7:5]);
    check("funct_decode", funct, instr[0]);
    PcWrite = pw; Jump = j; Bnez = b; bnez_cond = c; jr_target = jr;
    @(negedge clock);
    check("valid_update", instr_valid, 1);
    check("opcode_update", opCode, instr[7:5]);
    check("pc_update", pc, exp_pc);
    imem_bus.imem_ack = 1'b0;
    @(negedge clock);
    off = instr[4] ? int'(instr[4:0]) - 32 : int'(instr[4:0]);
    if (!pw) begin
      check("halt_flag", halted, 1);
      check("halt_pc", pc, exp_pc);
      check("halt_req", imem_bus.imem_req, 0);
    end else begin
      if (j)           exp_pc = jr;
      else if (b && c) exp_pc = ((exp_pc + off) % 256 + 256) % 256;
      else             exp_pc = (exp_pc + 1) % 256;
      check("next_pc", pc, exp_pc);
      check("next_req", imem_bus.imem_req, 1);
      check("next_halted", halted, 0);
      check("next_fault", fetch_fault, 0);
    end
  endtask

  initial begin
    imem_bus.imem_ack = 1'b0;
    imem_bus.imem_rdata = '0;
    do_reset();

    // Sequential fetch from 0
    for (int i = 0; i < 3; i++) begin
      check("seq_addr", imem_bus.imem_addr, i);
      run_instr(0, 8'h00, 1, 0, 0, 0, 8'h00);
    end
    check("seq_pc3", pc, 8'h03);

    // Branch taken / not taken at pc 5 with offset -2
    run_instr(0, 8'h00, 1, 1, 0, 0, 8'h05);
    run_instr(0, 8'h9E, 1, 0, 1, 1, 8'h00);
    check("br_taken", pc, 8'h03);
    run_instr(0, 8'h00, 1, 1, 0, 0, 8'h05);
    run_instr(0, 8'h9E, 1, 0, 1, 0, 8'h00);
    check("br_not_taken", pc, 8'h06);

    // Jump beats branch; wrap cases
    run_instr(0, 8'h00, 1, 1, 0, 0, 8'h10);
    run_instr(0, 8'h9E, 1, 1, 1, 1, 8'h40);
    check("jump_prio", pc, 8'h40);
    run_instr(0, 8'h00, 1, 1, 0, 0, 8'hFF);
    run_instr(0, 8'h00, 1, 0, 0, 0, 8'h00);
    check("wrap_inc", pc, 8'h00);
    run_instr(0, 8'h00, 1, 1, 0, 0, 8'h02);
    run_instr(0, 8'h9C, 1, 0, 1, 1, 8'h00);
    check("wrap_branch", pc, 8'hFE);

    // Ack delayed by 4 cycles
    run_instr(4, 8'h6B, 1, 0, 0, 0, 8'h00);

    // Randomized instruction stream
    for (int n = 0; n < 40; n++) begin
      run_instr($urandom_range(0, 3), 8'($urandom), 1'b1,
                ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 8'($urandom));
    end

    // Reset while a fetch is pending
    run_instr(0, 8'hA5, 1, 0, 0, 0, 8'h00);
    imem_bus.imem_ack = 1'b0;
    @(negedge clock);
    check("pending_req", imem_bus.imem_req, 1);
    reset = 1'b1;
    #1;
    check("async_req_drop", imem_bus.imem_req, 0);
    check("async_pc", pc, 8'h00);
    check("async_opcode", opCode, 0);
    do_reset();

    // Halt via PcWrite=0
    run_instr(0, 8'h00, 1, 0, 0, 0, 8'h00);
    run_instr(1, 8'hE1, 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 20; i++) begin
      imem_bus.imem_ack = ~imem_bus.imem_ack;
      imem_bus.imem_rdata = 8'($urandom);
      @(negedge clock);
      check("halt_hold_req", imem_bus.imem_req, 0);
      check("halt_hold_flag", halted, 1);
      check("halt_hold_pc", pc, exp_pc);
      check("halt_hold_op", {opCode, funct}, 4'hF);
    end

    // Never-acknowledged fetch
    do_reset();
`ifdef FETCH_TIMEOUT_EN
    for (int i = 0; i < 16; i++) begin
      check("to_req", imem_bus.imem_req, 1);
      check("to_fault_early", fetch_fault, 0);
      @(negedge clock);
    end
    check("to_fault", fetch_fault, 1);
    check("to_halted", halted, 1);
    check("to_req_drop", imem_bus.imem_req, 0);
    check("to_pc", pc, 8'h00);
`else
    repeat (100) @(negedge clock);
    check("wait_req", imem_bus.imem_req, 1);
    check("wait_fault", fetch_fault, 0);
    check("wait_halted", halted, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
